// File: rtl/cr16_mmio_responder.sv
// cr16_mmio_responder
// Register window on the CR16 external-memory port. Owns the 7-segment and
// LED registers the core writes. Presents synchronized switches, debounced
// push-button state and press events, and a prescaled tick timer for the
// core to read. Read data is registered so it arrives one cycle after the
// address, the same as a BRAM read.

module cr16_mmio_responder #(
   parameter logic [15:0] P_BASE_ADDRESS    = 16'hFF00,
   parameter logic [15:0] P_DEBOUNCE_CYCLES = 16'd50000,
   parameter logic [15:0] P_TICK_CYCLES     = 16'd50000
) (
   input  logic        I_CLK,
   input  logic        I_RESET,
   input  logic [15:0] I_ADDRESS,
   input  logic [15:0] I_DATA,
   input  logic        I_WRITE_ENABLE,
   output logic [15:0] O_DATA,
   input  logic [9:0]  I_SWITCHES,
   input  logic [3:0]  I_NBUTTONS,
   output logic [23:0] O_DISPLAY_BITS,
   output logic [4:0]  O_LEDS
);

   localparam logic [3:0] OFF_DISP_LO    = 4'h0;
   localparam logic [3:0] OFF_DISP_HI    = 4'h1;
   localparam logic [3:0] OFF_LEDS       = 4'h2;
   localparam logic [3:0] OFF_SWITCHES   = 4'h3;
   localparam logic [3:0] OFF_BTN_STATE  = 4'h4;
   localparam logic [3:0] OFF_BTN_EVENTS = 4'h5;
   localparam logic [3:0] OFF_TIMER      = 4'h6;

   localparam logic [15:0] DEBOUNCE_LAST = P_DEBOUNCE_CYCLES - 16'd1;
   localparam logic [15:0] TICK_LAST     = P_TICK_CYCLES - 16'd1;

   logic        hit;
   logic [3:0]  offset;
   logic        reg_write;

   logic [15:0] disp_lo;
   logic [7:0]  disp_hi;
   logic [4:0]  leds;

   logic [9:0]  sw_meta;
   logic [9:0]  sw_sync;
   logic [3:0]  btn_meta;
   logic [3:0]  btn_sync;

   logic [15:0] btn_count [4];
   logic [15:0] btn_count_next [4];
   logic [3:0]  btn_accepted;
   logic [3:0]  btn_accepted_next;
   logic [3:0]  btn_press;
   logic [3:0]  btn_events;
   logic [3:0]  btn_events_next;

   logic [15:0] timer;
   logic [15:0] prescale;

   logic [15:0] read_value;

   assign hit       = (I_ADDRESS[15:4] == P_BASE_ADDRESS[15:4]);
   assign offset    = I_ADDRESS[3:0];
   assign reg_write = I_WRITE_ENABLE && hit;

   assign O_DISPLAY_BITS = {disp_hi, disp_lo};
   assign O_LEDS         = leds;

   // Core-writable output registers: display digits and LEDs.
   always_ff @(posedge I_CLK) begin
      if (I_RESET) begin
         disp_lo <= 16'h0000;
         disp_hi <= 8'h00;
         leds    <= 5'h00;
      end else if (reg_write) begin
         if (offset == OFF_DISP_LO) disp_lo <= I_DATA;
         if (offset == OFF_DISP_HI) disp_hi <= I_DATA[7:0];
         if (offset == OFF_LEDS)    leds    <= I_DATA[4:0];
      end
   end

   // Two-flop synchronizers; buttons are inverted first so 1 means pressed
   // and the cleared reset state reads as released.
   always_ff @(posedge I_CLK) begin
      if (I_RESET) begin
         sw_meta  <= 10'h000;
         sw_sync  <= 10'h000;
         btn_meta <= 4'h0;
         btn_sync <= 4'h0;
      end else begin
         sw_meta  <= I_SWITCHES;
         sw_sync  <= sw_meta;
         btn_meta <= ~I_NBUTTONS;
         btn_sync <= btn_meta;
      end
   end

   // Debounce: a button's counter runs only while its synchronized level
   // disagrees with the accepted level; agreement (a glitch ending) clears it.
   always_comb begin
      btn_accepted_next = btn_accepted;
      btn_press         = 4'h0;
      for (int i = 0; i < 4; i++) begin
         btn_count_next[i] = 16'h0000;
         if (btn_sync[i] != btn_accepted[i]) begin
            if (btn_count[i] == DEBOUNCE_LAST) begin
               btn_accepted_next[i] = btn_sync[i];
               btn_press[i]         = btn_sync[i];
            end else begin
               btn_count_next[i] = btn_count[i] + 16'd1;
            end
         end
      end
      btn_events_next = btn_events;
      if (reg_write && (offset == OFF_BTN_EVENTS)) begin
         btn_events_next = btn_events & ~I_DATA[3:0];
      end
      btn_events_next = btn_events_next | btn_press;
   end

   // Debounce counters, accepted levels and sticky press flags.
   always_ff @(posedge I_CLK) begin
      if (I_RESET) begin
         for (int i = 0; i < 4; i++) begin
            btn_count[i] <= 16'h0000;
         end
         btn_accepted <= 4'h0;
         btn_events   <= 4'h0;
      end else begin
         for (int i = 0; i < 4; i++) begin
            btn_count[i] <= btn_count_next[i];
         end
         btn_accepted <= btn_accepted_next;
         btn_events   <= btn_events_next;
      end
   end

   // Tick timer; a core write reloads it and restarts the prescaler, and
   // takes priority over a tick landing on the same edge.
   always_ff @(posedge I_CLK) begin
      if (I_RESET) begin
         timer    <= 16'h0000;
         prescale <= 16'h0000;
      end else if (reg_write && (offset == OFF_TIMER)) begin
         timer    <= I_DATA;
         prescale <= 16'h0000;
      end else if (prescale == TICK_LAST) begin
         timer    <= timer + 16'd1;
         prescale <= 16'h0000;
      end else begin
         prescale <= prescale + 16'd1;
      end
   end

   // Read decode; misses and unmapped offsets return zero.
   always_comb begin
      read_value = 16'h0000;
      if (hit) begin
         case (offset)
            OFF_DISP_LO:    read_value = disp_lo;
            OFF_DISP_HI:    read_value = {8'h00, disp_hi};
            OFF_LEDS:       read_value = {11'h000, leds};
            OFF_SWITCHES:   read_value = {6'h00, sw_sync};
            OFF_BTN_STATE:  read_value = {12'h000, btn_accepted};
            OFF_BTN_EVENTS: read_value = {12'h000, btn_events};
            OFF_TIMER:      read_value = timer;
            default:        read_value = 16'h0000;
         endcase
      end
   end

   // Registered read data, so a same-cycle write is seen only on the next read.
   always_ff @(posedge I_CLK) begin
      if (I_RESET) begin
         O_DATA <= 16'h0000;
      end else begin
         O_DATA <= read_value;
      end
   end

endmodule
